// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: definitions shared by the serial frame controller and its
// bit counter.
//   state_t   - controller state encoding (idle / shifting / holding a frame)
//   LenAuto   - frame_len value that selects a full-width frame
//   clamp_len - maps a requested frame length to the effective length L
package serial_frame_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StHold  = 2'd2
    } state_t;

    // A frame_len of zero means "use the whole shift register".
    localparam int unsigned LenAuto = 0;

    // Out-of-range requests (zero or longer than the register) fall back to
    // the full register width so a frame can never overrun the data path.
    function automatic int unsigned clamp_len(int unsigned len, int unsigned width);
        if (len == LenAuto || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// frame_bit_counter: counts the bits sampled into the current frame.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset (count and length cleared)
//   load  - frame accepted: latch len and count the first bit (count = 1)
//   inc   - one more bit sampled this cycle
//   len   - effective frame length L, taken only on load
//   last  - the bit sampled this cycle is bit L-1 of the frame
module frame_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] len,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            len_q   <= '0;
        end else if (load) begin
            count_q <= CNT_W'(1);
            len_q   <= len;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // count_q holds the number of bits already sampled, so the bit being
    // sampled now is the final one when one more would reach L.
    assign last = (count_q + CNT_W'(1)) == len_q;

endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: assembles a serial bit stream into a parallel frame and
// holds it until the downstream side takes it.
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   start       - frame-start strobe; serial_in in the same cycle is bit 0
//   serial_in   - serial data, sampled when shift_en is high
//   frame_len   - requested frame length, taken on an accepted start
//   out_ready   - downstream accepts frame_data while frame_valid is high
//   shift_en    - a bit is sampled this cycle
//   frame_data  - assembled frame, first bit ends in bit L-1
//   frame_valid - frame_data complete and stable
//   busy        - controller not idle
//   overrun     - start ignored this cycle
module serial_frame_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serial_in,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             out_ready,
    output logic             shift_en,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    output logic             busy,
    output logic             overrun
);

    import serial_frame_pkg::*;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] eff_len;
    logic             accept;
    logic             cnt_last;

    assign eff_len = CNT_W'(clamp_len(32'(frame_len), WIDTH));

    // A new frame may start from idle, or from hold in the very cycle the
    // current frame is handed off, which gives back-to-back frames.
    assign accept = start & ((state_q == StIdle) | ((state_q == StHold) & out_ready));

    frame_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .inc  (state_q == StShift),
        .len  (eff_len),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else if (accept) begin
            // Fresh frame: drop the old contents so unused high bits read 0.
            data_q  <= {{(WIDTH-1){1'b0}}, serial_in};
            state_q <= (eff_len == CNT_W'(1)) ? StHold : StShift;
        end else begin
            case (state_q)
                StShift: begin
                    data_q <= {data_q[WIDTH-2:0], serial_in};
                    if (cnt_last) begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // shift_en and overrun depend on the live start input; gating with rst
    // keeps them low while reset is held even if start is asserted.
    assign shift_en    = ~rst & (accept | (state_q == StShift));
    assign overrun     = ~rst & start &
                         ((state_q == StShift) | ((state_q == StHold) & ~out_ready));
    assign frame_valid = (state_q == StHold);
    assign busy        = (state_q != StIdle);
    assign frame_data  = data_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
module tb_serial_frame_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             serial_in;
    logic [CNT_W-1:0] frame_len;
    logic             out_ready;
    logic             shift_en;
    logic [WIDTH-1:0] frame_data;
    logic             frame_valid;
    logic             busy;
    logic             overrun;

    serial_frame_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .serial_in   (serial_in),
        .frame_len   (frame_len),
        .out_ready   (out_ready),
        .shift_en    (shift_en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Expected per-cycle control outputs, consumed by the monitor.
    typedef struct {
        logic             sh;
        logic             ov;
        logic             v;
        logic             b;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t             ctrl_q[$];
    logic [WIDTH-1:0] frame_q[$];   // completed frames awaiting handshake
    int               checks   = 0;
    int               failures = 0;
    bit               held     = 1'b0;
    logic [WIDTH-1:0] held_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [CNT_W-1:0] rfl();
        return CNT_W'($urandom_range(0, 15));
    endfunction

    // Drive one cycle of inputs and record what the DUT must show in it.
    task automatic drive(input bit s, input bit si, input logic [CNT_W-1:0] fl, input bit rdy,
                         input bit e_sh, input bit e_ov, input bit e_v, input bit e_b,
                         input logic [WIDTH-1:0] e_d);
        exp_t e;
        start     = s;
        serial_in = si;
        frame_len = fl;
        out_ready = rdy;
        e.sh = e_sh;
        e.ov = e_ov;
        e.v  = e_v;
        e.b  = e_b;
        e.d  = e_d;
        ctrl_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, rb(), rfl(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Handshake cycle with no new start: last valid cycle of the held frame.
    task automatic release_frame();
        drive(1'b0, rb(), rfl(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, held_data);
        held = 1'b0;
    endtask

    // Send one frame. Bit k of the frame is word[L-1-k]. If a frame is
    // currently held, the start coincides with its handshake. Leaves the new
    // frame held after `hold` not-ready cycles; a start is tried at hold
    // cycle ov_at, and spur adds random starts during the bit phase.
    task automatic do_frame(input logic [CNT_W-1:0] fl, input logic [WIDTH-1:0] word,
                            input int hold, input int ov_at, input bit spur);
        int               len;
        logic             b[WIDTH];
        logic [WIDTH-1:0] exp;
        bit               fh;
        bit               s;
        len = (fl == 0 || int'(fl) > WIDTH) ? WIDTH : int'(fl);
        for (int k = 0; k < len; k++) b[k] = word[len-1-k];
        exp = '0;
        for (int k = 0; k < len; k++) begin
            if (b[k]) exp = exp + (WIDTH'(1) << (len - 1 - k));
        end
        fh = held;
        drive(1'b1, b[0], fl, fh ? 1'b1 : rb(), 1'b1, 1'b0, fh, fh, held_data);
        held = 1'b0;
        for (int k = 1; k < len; k++) begin
            s = spur && ($urandom_range(0, 3) == 0);
            drive(s, b[k], rfl(), rb(), 1'b1, s, 1'b0, 1'b1, '0);
        end
        frame_q.push_back(exp);
        for (int h = 0; h < hold; h++) begin
            s = (h == ov_at);
            drive(s, rb(), rfl(), 1'b0, 1'b0, s, 1'b1, 1'b1, exp);
        end
        held      = 1'b1;
        held_data = exp;
    endtask

    // Monitor: compares every cycle against the expected controls, and each
    // handshake against the oldest completed frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ctrl_q.size() > 0) begin
                e = ctrl_q.pop_front();
                chk("shift_en", 32'(shift_en), 32'(e.sh));
                chk("overrun", 32'(overrun), 32'(e.ov));
                chk("frame_valid", 32'(frame_valid), 32'(e.v));
                chk("busy", 32'(busy), 32'(e.b));
                if (e.v) chk("frame_data_hold", 32'(frame_data), 32'(e.d));
            end
            if (frame_valid && out_ready && !rst) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%0h expected=none at %0t",
                             frame_data, $time);
                end else begin
                    chk("frame_data_handshake", 32'(frame_data), 32'(frame_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        serial_in = 1'b0;
        frame_len = '0;
        out_ready = 1'b0;
        #1;
        chk("reset_shift_en", 32'(shift_en), 32'd0);
        chk("reset_frame_valid", 32'(frame_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_frame_data", 32'(frame_data), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); // start under reset ignored
        rst = 1'b0;
        idle(2);

        // Full-width frame, immediate handshake.
        do_frame(4'd8, 8'hB2, 0, -1, 1'b0);
        release_frame();
        idle(1);

        // Short frame held for five cycles, one rejected start during hold.
        do_frame(4'd3, 8'h06, 5, 2, 1'b0);
        release_frame();
        idle(1);

        // Zero and oversize lengths both fall back to full width.
        do_frame(4'd0, 8'h3C, 0, -1, 1'b0);
        release_frame();
        do_frame(4'd12, 8'hC3, 1, -1, 1'b0);
        release_frame();
        idle(1);

        // Back-to-back frames: new start in the handshake cycle.
        do_frame(4'd8, 8'hB2, 0, -1, 1'b0);
        do_frame(4'd8, 8'h5C, 0, -1, 1'b0);
        release_frame();
        idle(1);

        // Reset after the fourth bit of a frame, then a clean frame.
        drive(1'b1, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k < 4; k++) drive(1'b0, 1'b1, rfl(), rb(), 1'b1, 1'b0, 1'b0, 1'b1, '0);
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("midreset_shift_en", 32'(shift_en), 32'd0);
        chk("midreset_frame_valid", 32'(frame_valid), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_overrun", 32'(overrun), 32'd0);
        chk("midreset_frame_data", 32'(frame_data), 32'd0);
        drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        idle(1);
        do_frame(4'd8, 8'hA5, 0, -1, 1'b0);
        release_frame();
        idle(1);

        // Single-bit frame.
        do_frame(4'd1, 8'h01, 0, -1, 1'b0);
        release_frame();
        idle(2);

        // Randomized frames, lengths, holds, spurious starts and chaining.
        for (int i = 0; i < 60; i++) begin
            do_frame(rfl(), WIDTH'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b1);
            if (rb()) begin
                release_frame();
                idle($urandom_range(0, 2));
            end
        end
        if (held) release_frame();
        idle(2);
        @(negedge clk);
        chk("frames_drained", 32'(frame_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_ctrl.md
SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: shift-register width and maximum frame length in bits.
REQ-002 Parameter CNT_W, default 4: counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  frame-start strobe; serial_in in the same cycle is frame bit 0.
REQ-006 serial_in  in  1  serial data bit, sampled only when shift_en=1.
REQ-007 frame_len  in  CNT_W  bits per frame, sampled only on an accepted start.
REQ-008 out_ready  in  1  downstream accepts frame_data when frame_valid=1.
REQ-009 shift_en  out  1  shift enable; high in every cycle a bit is sampled.
REQ-010 frame_data  out  WIDTH  assembled frame.
REQ-011 frame_valid  out  1  frame_data complete and stable.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 overrun  out  1  one-cycle pulse when a start is rejected.

Function
REQ-014 The state machine SHALL have three states: IDLE, SHIFT and HOLD.
REQ-015 The effective length L SHALL be frame_len, except that frame_len=0 or frame_len>WIDTH gives L=WIDTH; L is latched on an accepted start.
REQ-016 An accepted start SHALL clear the shift register, shift in serial_in, set bit count to 1, and move to SHIFT (or to HOLD if L=1).
REQ-017 Shift rule: on each sampled bit, data <= {data[WIDTH-2:0], serial_in}; first bit ends in bit L-1, bits above L-1 are 0.
REQ-018 In SHIFT, shift_en SHALL be 1 every cycle; count increments per bit; on the edge that samples bit L-1, the state moves to HOLD.
REQ-019 Latency: bit k is sampled at edge Ek (k=0..L-1, E0 = start edge); frame_valid SHALL be 1 immediately after edge E(L-1).
REQ-020 In HOLD: frame_valid=1, shift_en=0, frame_data unchanged until handshake (frame_valid & out_ready).
REQ-021 Handshake with start=0 SHALL return to IDLE; frame_valid is 0 the next cycle.
REQ-022 Handshake with start=1 in the same cycle SHALL accept the new frame (REQ-016), with no idle gap.
REQ-023 start in SHIFT, or in HOLD without out_ready, SHALL be ignored and SHALL pulse overrun for exactly that cycle.
REQ-024 start in IDLE SHALL always be accepted; overrun stays 0.
REQ-025 shift_en SHALL be 1 in IDLE or HOLD only in a cycle where a start is accepted.
REQ-026 frame_len changes outside an accepted start SHALL not affect the frame in progress.

Reset
REQ-027 Reset=1 SHALL force IDLE, count=0, frame_data=0, frame_valid=0, shift_en=0, busy=0 and overrun=0, in any state and mid-frame.
REQ-028 The first start accepted after Reset deasserts SHALL behave as per REQ-016; a partial frame SHALL never be emitted.

Structure
REQ-029 The state encodings (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2) and the length-clamp rule constants SHALL live in shared package serial_frame_pkg.
REQ-030 The bit counter SHALL be a sub-module frame_bit_counter (clear, increment, terminal-count compare to L); the shift register and FSM stay in serial_frame_ctrl.

Verification
REQ-031 WIDTH=8, L=8, bits 1,0,1,1,0,0,1,0 from start, out_ready=1 -> frame_valid after E7, frame_data=8'hB2, single-cycle valid, then IDLE.
REQ-032 frame_len=3, bits 1,1,0, out_ready=0 for 5 cycles -> frame_data=8'h06 held with frame_valid=1 for 5 cycles; a start during the hold pulses overrun once.
REQ-033 frame_len=0, then frame_len=12 -> each treated as L=8; frame_valid after E7.
REQ-034 start asserted with out_ready in the handshake cycle of frame A=8'hB2, then bits of 8'h5C -> frame_valid low exactly one cycle later; second frame 8'h5C after 8 edges.
REQ-035 Reset pulsed after the 4th bit of a frame -> all outputs 0 asynchronously; next frame 8'hA5 assembles correctly with no residue.
REQ-036 frame_len=1, serial_in=1 with start -> frame_valid after E0, frame_data=8'h01, busy high for one cycle with out_ready=1.
